// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the IO register file.
// slave = arbiter view; master = requester/IO-register-file view.
interface io_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        io_valid;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output io_valid, io_we, io_addr, io_wdata,
        input  io_rdata, io_ready
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  io_valid, io_we, io_addr, io_wdata,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO register port between m0 and m1, with
// read/write bank decode, wait-state handshake and timeout abort.
module io_bus_arbiter #(
    parameter logic [31:0] IO_START = 32'h0002_0000,
    parameter logic [31:0] WR_BASE  = 32'h0003_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst,
    io_bus_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DERR, RESP} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q,  last_d;
    logic [1:0]      gnt_q,   gnt_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            we_q,    we_d;
    logic [31:0]     addr_q,  addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q,   err_d;

    logic [1:0]      req;
    logic            sel;
    logic            sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            dec_err;

    assign req = {bus.m1_req, bus.m0_req};
    // On a tie the requester not granted last wins; otherwise the sole requester.
    assign sel       = (req == 2'b11) ? ~last_q : req[1];
    assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    assign dec_err   = (sel_addr < IO_START) ||
                       (!sel_we && (sel_addr >= WR_BASE)) ||
                       ( sel_we && (sel_addr <  WR_BASE));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = 2'b00;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = sel;
                    last_d     = sel;
                    gnt_d[sel] = 1'b1;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    cnt_d      = '0;
                    state_d    = dec_err ? DERR : ACCESS;
                end
            end
            ACCESS: begin
                // io_ready on the final wait cycle still completes the access
                if (bus.io_ready) begin
                    rdata_d = we_q ? 32'h0 : bus.io_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DERR: begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic rv0, rv1;
    assign rv0 = (state_q == RESP) && !owner_q;
    assign rv1 = (state_q == RESP) &&  owner_q;

    assign bus.m0_gnt    = gnt_q[0];
    assign bus.m1_gnt    = gnt_q[1];
    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_rdata  = rv0 ? rdata_q : 32'h0;
    assign bus.m1_rdata  = rv1 ? rdata_q : 32'h0;
    assign bus.m0_err    = rv0 & err_q;
    assign bus.m1_err    = rv1 & err_q;

    assign bus.io_valid  = (state_q == ACCESS);
    assign bus.io_we     = we_q;
    assign bus.io_addr   = addr_q;
    assign bus.io_wdata  = wdata_q;
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO register port between two requesters: m0 (core load/store path) and m1 (debug/DMA path).
- Round-robin arbitration and address/direction decode against the IO map (read bank at IO_START, write bank at IO_START+IO_START/2).
- Wait-state handshake to the IO register file, timeout abort, and a one-cycle response pulse back to the owning requester.

Parameters:
- IO_START, 32'h0002_0000, base of IO space; addresses below it are decode errors.
- WR_BASE, 32'h0003_0000, start of the write-only bank; [IO_START, WR_BASE) is read-only.
- TIMEOUT, 15, maximum wait cycles with io_valid high and io_ready low before abort; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mN_req  in  1  request (N=0,1), held until gnt seen
- mN_we  in  1  1=write, 0=read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data
- mN_gnt  out  1  one-cycle acceptance pulse
- mN_rvalid  out  1  one-cycle response pulse
- mN_rdata  out  32  read data, valid with rvalid
- mN_err  out  1  error flag, valid with rvalid
- io_valid  out  1  access strobe to IO registers
- io_we  out  1  access direction
- io_addr  out  32  latched address
- io_wdata  out  32  latched write data
- io_rdata  in  32  read data from IO registers
- io_ready  in  1  access complete this cycle

Behaviour:
- Reset: state=IDLE; all outputs 0; wait counter 0; last-grant pointer = m1, so m0 wins the first tie. Reset asserted mid-access drops io_valid immediately; no rvalid is issued for the aborted access.
- States: IDLE, ACCESS, DERR, RESP.
- IDLE, on a rising edge with any req:
  - Select a requester: the only one requesting, or on a tie the one not granted last. Update the pointer.
  - Latch we, addr and wdata into io_*.
  - Decode: addr < IO_START, or (we=0 and addr >= WR_BASE), or (we=1 and addr < WR_BASE) -> DERR. Otherwise -> ACCESS.
- Grant: the selected mN_gnt is high for exactly the first cycle of ACCESS or DERR. The requester may drop req at that edge. A req still high in RESP is not resampled until IDLE.
- ACCESS:
  - io_valid=1; io_we, io_addr and io_wdata stay stable for the whole state.
  - On an edge with io_ready=1: capture io_rdata (reads only; writes capture 0), err=0, go to RESP.
  - On an edge with io_ready=0: counter+1. When the counter reaches TIMEOUT, go to RESP with err=1 and rdata=0. io_ready on that same edge wins over the timeout.
- DERR: one cycle with io_valid=0 and no IO side effects, then RESP with err=1 and rdata=0.
- RESP:
  - Owner's rvalid=1 for one cycle, with rdata/err. The other requester's outputs stay 0.
  - Clear the counter and go to IDLE.
  - rdata and err are 0 whenever rvalid is 0.
- Latency: req sampled at edge E0 -> gnt and io_valid in cycle E0+1. With io_ready in that cycle, rvalid appears in cycle E0+2. Best-case throughput is one access per 3 cycles.
- Alignment: addr[1:0] is ignored and passed through unchanged; the IO register file indexes on addr[15:2].
- The non-owner's req is ignored outside IDLE. There is no starvation: strict alternation holds under continuous dual requests.

Test Plan:
- Single read: m0 reads 32'h0002_0004, io_ready in the first ACCESS cycle with io_rdata=32'hDEADBEEF -> m0_gnt in cycle 1; io_valid=1, io_we=0 in cycle 1; m0_rvalid=1, m0_rdata=32'hDEADBEEF, m0_err=0 in cycle 2.
- Write with 3 wait states: m1 writes 32'h0000_00A5 to 32'h0003_0008, io_ready on the 4th ACCESS cycle -> io_addr and io_wdata stable for 4 cycles; m1_rvalid=1, m1_err=0, m1_rdata=0 one cycle later.
- Round-robin: m0 and m1 both hold req continuously, 4 accesses -> grant order m0, m1, m0, m1; grants are 3 cycles apart.
- Decode errors: m0 reads 32'h0000_1000, then writes 32'h0002_0000, then reads 32'h0003_0000 -> each gives gnt, then DERR, then rvalid with err=1; io_valid never asserts.
- Timeout: TIMEOUT=15, io_ready held low -> io_valid high for 15 cycles, then rvalid with err=1, rdata=0. A repeat run with io_ready on the 15th cycle -> err=0.
- Reset mid-access: rst pulsed during ACCESS -> io_valid, gnt and rvalid go 0 asynchronously; after release, a tie is granted to m0 first.
